// File: rtl/ethgen_pkg.sv
// Shared definitions for the Ethernet traffic generator and its receive-side checker.
// Holds the beat field layout, the default packet length, error-bit indices and the
// checker state encoding. The generator builds beats with the same field offsets.
package ethgen_pkg;

  localparam int unsigned BEAT_W  = 512;
  localparam int unsigned FIELD_W = 64;

  // Field offsets inside a 512-bit beat
  localparam int unsigned OFF_COUNTER   = 0;
  localparam int unsigned OFF_PKT_NUM   = 64;
  localparam int unsigned OFF_PKT_NUM_N = 384;
  localparam int unsigned OFF_COUNTER_N = 448;

  localparam logic [7:0] DEFAULT_PKT_LEN = 8'd4;

  // Error-bit indices into err_flags and the per-beat error vector
  localparam int unsigned ERR_COUNTER = 0;
  localparam int unsigned ERR_PKT_NUM = 1;
  localparam int unsigned ERR_COMPL   = 2;
  localparam int unsigned ERR_FRAMING = 3;
  localparam int unsigned NUM_ERR     = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // A programmed length of zero selects the default packet length.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? DEFAULT_PKT_LEN : len;
  endfunction

endpackage

// File: rtl/beat_compare.sv
// First pipeline stage of the data checker: compares one accepted beat against the
// current expectations and registers the 4-bit error vector with the beat index.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop whatever the stage holds (start of a new run)
//   in_valid        beat accepted this cycle
//   data, last      beat payload and TLAST
//   exp_counter     expected counter field
//   exp_pkt         expected packet_num field
//   exp_last        TLAST is expected on this beat
//   beat_index      0-based index of this beat within the run
//   final_beat      this beat completes the run
//   out_valid       registered: stage holds a beat
//   err             registered error vector (see ERR_* indices)
//   out_index       registered beat index
//   out_final       registered final-beat marker
module beat_compare
  import ethgen_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [BEAT_W-1:0]    data,
  input  logic                 last,
  input  logic                 exp_last,
  input  logic [FIELD_W-1:0]   exp_counter,
  input  logic [FIELD_W-1:0]   exp_pkt,
  input  logic [FIELD_W-1:0]   beat_index,
  input  logic                 final_beat,
  output logic                 out_valid,
  output logic [NUM_ERR-1:0]   err,
  output logic [FIELD_W-1:0]   out_index,
  output logic                 out_final
);

  logic [FIELD_W-1:0] counter_f;
  logic [FIELD_W-1:0] pkt_f;
  logic [FIELD_W-1:0] pkt_n_f;
  logic [FIELD_W-1:0] counter_n_f;
  logic [NUM_ERR-1:0] err_d;

  assign counter_f   = data[OFF_COUNTER   +: FIELD_W];
  assign pkt_f       = data[OFF_PKT_NUM   +: FIELD_W];
  assign pkt_n_f     = data[OFF_PKT_NUM_N +: FIELD_W];
  assign counter_n_f = data[OFF_COUNTER_N +: FIELD_W];

  // Middle of the beat carries no checked fields
  logic unused_payload;
  assign unused_payload = ^data[OFF_PKT_NUM_N-1:OFF_PKT_NUM+FIELD_W];

  always_comb begin
    err_d              = '0;
    err_d[ERR_COUNTER] = (counter_f != exp_counter);
    err_d[ERR_PKT_NUM] = (pkt_f != exp_pkt);
    // Complements are checked against the received fields, not the expectations
    err_d[ERR_COMPL]   = (pkt_n_f != ~pkt_f) || (counter_n_f != ~counter_f);
    err_d[ERR_FRAMING] = (last != exp_last);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      err       <= '0;
      out_index <= '0;
      out_final <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        err       <= err_d;
        out_index <= beat_index;
        out_final <= final_beat;
      end
    end
  end

endmodule

// File: rtl/data_checker.sv
// Receive-side checker for the traffic generator's AXI-Stream packet format.
// Validates counter, packet number, complement fields and TLAST framing of each
// beat, and accumulates beat/packet/error statistics. Never backpressures while armed.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   packet_count             packets expected in a run (sampled on start)
//   packet_length            beats per packet, 0 selects 4 (sampled on start)
//   start                    one-cycle pulse: arm and clear statistics
//   AXIS_RX_*                AXI-Stream receive channel
//   busy, done, pass         run status
//   beats_received           accepted beats this run
//   packets_received         accepted TLAST beats this run
//   error_count              beats with at least one error, saturating
//   err_flags                sticky error classes
//   first_err_beat           index of first erroring beat
module data_checker
  import ethgen_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          packet_count,
  input  logic [7:0]           packet_length,
  input  logic                 start,
  input  logic [511:0]         AXIS_RX_TDATA,
  input  logic                 AXIS_RX_TVALID,
  input  logic                 AXIS_RX_TLAST,
  output logic                 AXIS_RX_TREADY,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [63:0]          beats_received,
  output logic [63:0]          packets_received,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [3:0]           err_flags,
  output logic [63:0]          first_err_beat
);

  state_e state_q, state_d;

  logic [63:0]          count_q;
  logic [7:0]           len_q;
  logic [63:0]          exp_counter_q;
  logic [63:0]          exp_pkt_q;
  logic [7:0]           cycle_index_q;
  logic [63:0]          beats_q;
  logic [63:0]          packets_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [NUM_ERR-1:0]   flags_q;
  logic [63:0]          first_q;
  logic                 done_q;
  logic                 s2_valid_q;

  logic               tready;
  logic               accept;
  logic               is_final;
  logic               s1_valid;
  logic [NUM_ERR-1:0] s1_err;
  logic [63:0]        s1_index;
  logic               s1_final;

  assign tready = (state_q == RUN);
  // start wins over a coincident beat: the beat is dropped
  assign accept   = AXIS_RX_TVALID && tready && !start;
  assign is_final = accept && AXIS_RX_TLAST && ((packets_q + 64'd1) == count_q);

  // FSM
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (packet_count == 64'd0) ? DONE : RUN;
    end else if (is_final) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // S1: field comparison
  beat_compare u_beat_compare (
    .clk         (clk),
    .reset       (reset),
    .flush       (start),
    .in_valid    (accept),
    .data        (AXIS_RX_TDATA),
    .last        (AXIS_RX_TLAST),
    .exp_last    (cycle_index_q == len_q),
    .exp_counter (exp_counter_q),
    .exp_pkt     (exp_pkt_q),
    .beat_index  (beats_q),
    .final_beat  (is_final),
    .out_valid   (s1_valid),
    .err         (s1_err),
    .out_index   (s1_index),
    .out_final   (s1_final)
  );

  // Expectations, counters and S2 accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      len_q         <= '0;
      exp_counter_q <= '0;
      exp_pkt_q     <= '0;
      cycle_index_q <= '0;
      beats_q       <= '0;
      packets_q     <= '0;
      err_count_q   <= '0;
      flags_q       <= '0;
      first_q       <= '0;
      done_q        <= 1'b0;
      s2_valid_q    <= 1'b0;
    end else if (start) begin
      count_q       <= packet_count;
      len_q         <= eff_len(packet_length);
      exp_counter_q <= '0;
      exp_pkt_q     <= '0;
      cycle_index_q <= 8'd1;
      beats_q       <= '0;
      packets_q     <= '0;
      err_count_q   <= '0;
      flags_q       <= '0;
      first_q       <= '0;
      done_q        <= (packet_count == 64'd0);
      s2_valid_q    <= 1'b0;
    end else begin
      if (accept) begin
        exp_counter_q <= exp_counter_q + 64'd1;
        beats_q       <= beats_q + 64'd1;
        if (AXIS_RX_TLAST) begin
          exp_pkt_q     <= exp_pkt_q + 64'd1;
          cycle_index_q <= 8'd1;
          packets_q     <= packets_q + 64'd1;
        end else if (cycle_index_q != len_q) begin
          // Holding at the length keeps overlong packets flagging framing
          cycle_index_q <= cycle_index_q + 8'd1;
        end
      end

      s2_valid_q <= s1_valid;
      if (s1_valid) begin
        if (s1_err != '0) begin
          if (err_count_q != '1) begin
            err_count_q <= err_count_q + ERR_CNT_W'(1);
          end
          if (flags_q == '0) begin
            first_q <= s1_index;
          end
          flags_q <= flags_q | s1_err;
        end
        // done rises together with the final beat's error update
        if (s1_final) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign AXIS_RX_TREADY   = tready;
  assign busy             = tready || s1_valid || s2_valid_q;
  assign done             = done_q;
  assign pass             = done_q && (err_count_q == '0);
  assign beats_received   = beats_q;
  assign packets_received = packets_q;
  assign error_count      = err_count_q;
  assign err_flags        = flags_q;
  assign first_err_beat   = first_q;

endmodule

// File: tb/tb_data_checker.sv
// Randomized self-checking bench for data_checker with a queue-based reference model.
module tb_data_checker;

  localparam int unsigned ErrW = 4;
  localparam int unsigned ErrMax = (1 << ErrW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     packet_count;
  logic [7:0]      packet_length;
  logic            start;
  logic [511:0]    tdata;
  logic            tvalid;
  logic            tlast;
  logic            tready;
  logic            busy;
  logic            done;
  logic            pass;
  logic [63:0]     beats_received;
  logic [63:0]     packets_received;
  logic [ErrW-1:0] error_count;
  logic [3:0]      err_flags;
  logic [63:0]     first_err_beat;

  always #5 clk = ~clk;

  data_checker #(
    .ERR_CNT_W (ErrW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .packet_count     (packet_count),
    .packet_length    (packet_length),
    .start            (start),
    .AXIS_RX_TDATA    (tdata),
    .AXIS_RX_TVALID   (tvalid),
    .AXIS_RX_TLAST    (tlast),
    .AXIS_RX_TREADY   (tready),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .beats_received   (beats_received),
    .packets_received (packets_received),
    .error_count      (error_count),
    .err_flags        (err_flags),
    .first_err_beat   (first_err_beat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beats the bench intends to deliver in the current run
  logic [511:0] q_data[$];
  bit           q_last[$];

  // Model results
  logic [63:0] m_beats, m_pkts, m_errs, m_first;
  logic [3:0]  m_flags;

  function automatic logic [511:0] mk_beat(input logic [63:0] c, input logic [63:0] p);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    d[63:0]    = c;
    d[127:64]  = p;
    d[447:384] = ~p;
    d[511:448] = ~c;
    return d;
  endfunction

  task automatic push_beat(input logic [63:0] c, input logic [63:0] p, input bit last);
    q_data.push_back(mk_beat(c, p));
    q_last.push_back(last);
  endtask

  // Random run: some packets get a random length, some beats get one flipped field bit
  task automatic gen_run(input int count, input int len_eff, input int inj_pct,
                         input int frame_pct);
    int offs[4] = '{0, 64, 384, 448};
    logic [63:0] k = 0;
    q_data.delete();
    q_last.delete();
    for (int p = 0; p < count; p++) begin
      int plen = len_eff;
      if ($urandom_range(99) < frame_pct) plen = $urandom_range(len_eff + 2, 1);
      for (int b = 0; b < plen; b++) begin
        logic [511:0] d = mk_beat(k, 64'(p));
        if ($urandom_range(99) < inj_pct) begin
          int f = $urandom_range(3);
          int bitpos = offs[f] + $urandom_range(63);
          d[bitpos] = ~d[bitpos];
        end
        q_data.push_back(d);
        q_last.push_back(b == plen - 1);
        k++;
      end
    end
  endtask

  // Reference: evaluate the whole delivered beat list against the checking rules
  task automatic model(input int len_eff);
    logic [63:0] pk = 0;
    int since = 0;
    m_beats = 0; m_pkts = 0; m_errs = 0; m_first = 0; m_flags = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      logic [511:0] d = q_data[i];
      logic [3:0] e = 0;
      int pos = (since + 1 > len_eff) ? len_eff : since + 1;
      e[0] = (d[63:0] != 64'(i));
      e[1] = (d[127:64] != pk);
      e[2] = (d[447:384] != ~d[127:64]) || (d[511:448] != ~d[63:0]);
      e[3] = (q_last[i] != (pos == len_eff));
      if (e != 0) begin
        if (m_flags == 0) m_first = 64'(i);
        m_flags = m_flags | e;
        if (m_errs < 64'(ErrMax)) m_errs++;
      end
      m_beats++;
      if (q_last[i]) begin
        pk++;
        since = 0;
      end else begin
        since++;
      end
    end
    m_pkts = pk;
  endtask

  task automatic do_start(input logic [63:0] cnt, input logic [7:0] len);
    start = 1'b1;
    packet_count = cnt;
    packet_length = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted
  task automatic drive(input int gap_pct, output int drops);
    drops = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      int n = 0;
      while ($urandom_range(99) < gap_pct) begin
        tvalid = 1'b0;
        @(negedge clk);
        if (!tready) drops++;
        @(posedge clk); #1;
      end
      tdata  = q_data[i];
      tlast  = q_last[i];
      tvalid = 1'b1;
      forever begin
        @(negedge clk);
        if (tready) break;
        drops++;
        n++;
        if (n > 200) break;
      end
      if (n > 200) begin
        check("handshake_timeout", 64'(tready), 64'd1);
        tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":done"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":tready"}, 64'(tready), 64'd0);
    check({tag, ":pass"}, 64'(pass), 64'(m_errs == 0));
    check({tag, ":beats"}, beats_received, m_beats);
    check({tag, ":pkts"}, packets_received, m_pkts);
    check({tag, ":errs"}, 64'(error_count), m_errs);
    check({tag, ":flags"}, 64'(err_flags), 64'(m_flags));
    check({tag, ":first"}, first_err_beat, m_first);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":tready"}, 64'(tready), 64'd0);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":pass"}, 64'(pass), 64'd0);
    check({tag, ":beats"}, beats_received, 64'd0);
    check({tag, ":pkts"}, packets_received, 64'd0);
    check({tag, ":errs"}, 64'(error_count), 64'd0);
    check({tag, ":flags"}, 64'(err_flags), 64'd0);
    check({tag, ":first"}, first_err_beat, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drops;
    reset = 1'b1; start = 1'b0; packet_count = '0; packet_length = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");

    // Clean loopback, default length
    gen_run(3, 4, 0, 0);
    model(4);
    do_start(64'd3, 8'd0);
    drive(0, drops);
    finish_run("clean");
    check("clean:beat_total", beats_received, 64'd12);

    // Counter field corrupted on beat 5 (complement kept consistent)
    q_data.delete(); q_last.delete();
    for (int i = 0; i < 8; i++) push_beat(64'(i), 64'(i / 4), (i % 4) == 3);
    q_data[5][63:0]    = 64'd999;
    q_data[5][511:448] = ~64'd999;
    model(4);
    do_start(64'd2, 8'd4);
    drive(0, drops);
    finish_run("ctr_err");
    check("ctr_err:flags_const", 64'(err_flags), 64'b0001);

    // Early TLAST on beat 2 of packet 0, then a correct 4-beat packet
    q_data.delete(); q_last.delete();
    push_beat(0, 0, 0); push_beat(1, 0, 1);
    for (int i = 2; i < 6; i++) push_beat(64'(i), 1, i == 5);
    model(4);
    do_start(64'd2, 8'd4);
    drive(0, drops);
    finish_run("early_last");

    // Random TVALID gaps; TREADY must stay high during the run
    gen_run(5, 7, 0, 0);
    model(7);
    do_start(64'd5, 8'd7);
    drive(50, drops);
    check("gaps:tready_drops", 64'(drops), 64'd0);
    finish_run("gaps");

    // Abort after 3 beats with errors in flight; coincident beat must be dropped
    q_data.delete(); q_last.delete();
    for (int i = 0; i < 3; i++) push_beat(64'(i), 0, 0);
    q_data[1][63:0] = 64'd77;
    q_data[2][127:64] = 64'd55;
    do_start(64'd2, 8'd4);
    drive(0, drops);
    tdata = mk_beat(64'd1234, 64'd9);
    tvalid = 1'b1;
    tlast = 1'b1;
    do_start(64'd2, 8'd4);
    tvalid = 1'b0;
    tlast = 1'b0;
    @(negedge clk);
    check("abort:flags_clear", 64'(err_flags), 64'd0);
    check("abort:errs_clear", 64'(error_count), 64'd0);
    check("abort:beats_clear", beats_received, 64'd0);
    @(posedge clk); #1;
    gen_run(2, 4, 0, 0);
    model(4);
    drive(0, drops);
    finish_run("after_abort");

    // Saturation: 20 single-beat packets, every counter field wrong
    q_data.delete(); q_last.delete();
    for (int i = 0; i < 20; i++) begin
      push_beat(64'(i + 100), 64'(i), 1);
      q_data[i][511:448] = ~q_data[i][63:0];
    end
    model(1);
    do_start(64'd20, 8'd1);
    drive(20, drops);
    finish_run("saturate");
    check("saturate:const", 64'(error_count), 64'(ErrMax));

    // packet_count == 0 completes immediately
    do_start(64'd0, 8'd3);
    check("zero:done", 64'(done), 64'd1);
    check("zero:pass", 64'(pass), 64'd1);
    check("zero:tready", 64'(tready), 64'd0);
    @(posedge clk); #1;

    // Random runs with corruption and random packet lengths
    for (int r = 0; r < 6; r++) begin
      int cnt = $urandom_range(4, 1);
      int len = $urandom_range(6);
      int le = (len == 0) ? 4 : len;
      gen_run(cnt, le, 15, 25);
      model(le);
      do_start(64'(cnt), 8'(len));
      drive(30, drops);
      finish_run($sformatf("rand%0d", r));
    end

    // Reset mid-run with an error in the pipeline
    q_data.delete(); q_last.delete();
    for (int i = 0; i < 6; i++) push_beat(64'(i), 64'(i / 4), (i % 4) == 3);
    q_data[4][127:64] = 64'd3;
    do_start(64'd5, 8'd4);
    drive(0, drops);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("midreset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_checker.md
# data_checker

Receive-side checker for the Ethernet traffic generator's AXI-Stream packet format. It consumes 512-bit beats arriving back from the link/loopback and validates each one: the beat counter, the packet number, both complement fields, and packet framing (TLAST position). It accumulates beat, packet and error statistics for the control/status register block. It always accepts data while armed; it never applies backpressure.

## Interface
Parameters:
- ERR_CNT_W, 32, width of saturating error counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- packet_count  in  64  packets expected in a run; sampled on start
- packet_length  in  8  beats per packet; sampled on start; 0 means 4
- start  in  1  one-cycle pulse; arms the checker and clears statistics
- AXIS_RX_TDATA  in  512  beat payload
- AXIS_RX_TVALID  in  1  beat valid
- AXIS_RX_TLAST  in  1  last beat of packet
- AXIS_RX_TREADY  out  1  1 while armed (state RUN), else 0
- busy  out  1  run in progress
- done  out  1  run complete; sticky until next start/reset
- pass  out  1  done and error_count==0
- beats_received  out  64  accepted beats this run
- packets_received  out  64  accepted TLAST beats this run
- error_count  out  ERR_CNT_W  beats with ≥1 error; saturates at all-ones
- err_flags  out  4  sticky: [0] counter field, [1] packet_num field, [2] complement fields, [3] framing
- first_err_beat  out  64  beat index (0-based) of first erroring beat; valid when err_flags≠0

## Operation
- Beat fields: [63:0] counter, [127:64] packet_num, [447:384] ~packet_num, [511:448] ~counter; other bits ignored.
- States:
  - IDLE: reset/power-up state.
  - RUN: armed and accepting beats.
  - DONE: run complete.
- Transitions:
  - start in any state → RUN. Latch packet_count and packet_length (0→4). exp_counter=0, exp_pkt=0, cycle_index=1. Clear all statistics, flags, done.
  - start with packet_count==0 → DONE directly, pass=1.
- Accepted beat = TVALID & TREADY. On each accepted beat:
  - counter error if field ≠ exp_counter.
  - packet_num error if field ≠ exp_pkt.
  - complement error if either complement field ≠ bitwise inverse of its partner field in the same beat.
  - framing error if TLAST ≠ (cycle_index==latched length).
- Expectation update per accepted beat:
  - exp_counter +1 (64-bit wrap).
  - If TLAST: exp_pkt +1, cycle_index←1, packets_received +1.
  - Else cycle_index +1; at latched length it holds (no wrap), so overlong packets keep flagging framing.
  - Resync is on TLAST only; expectations never track received values.
- Run ends on the accepted TLAST that makes packets_received == packet_count → DONE, TREADY drops.
- start mid-run aborts immediately. Pipelined results from the aborted run are discarded.

## Timing
- Reset values: TREADY 0, busy 0, done 0, pass 0, all counters/flags/first_err_beat 0, state IDLE.
- TREADY is registered: it goes 1 the cycle after start and 0 the cycle after the final TLAST is accepted.
- Two-stage pipeline:
  - S1 registers the four compare results plus the beat's 64-bit index.
  - S2 updates error_count, err_flags and first_err_beat.
  - Status for beat N is visible 2 cycles after acceptance.
- beats_received and packets_received update 1 cycle after acceptance.
- done and pass assert 2 cycles after the final beat, so they always reflect all errors.
- busy = (state==RUN) or S1/S2 holding a valid beat.
- A beat with multiple errors increments error_count once and sets every applicable flag.
- first_err_beat is captured only while err_flags==0.
- start coincident with an accepted beat: the beat is discarded; start wins.

## Structure
- Shared package ethgen_pkg:
  - Field offsets 0/64/384/448, FIELD_W=64.
  - DEFAULT_PKT_LEN=4.
  - Error-bit indices.
  - State enum {IDLE, RUN, DONE}.
  - The generator uses the same field offsets.
- Sub-module beat_compare: S1 stage, 512-bit beat plus expectations in, registered 4-bit error vector plus valid out.
- Top level holds the FSM, expectation counters and S2 accumulation.

## Test plan
- Loopback from the traffic generator, packet_count=3, packet_length=0 → 12 beats, packets_received=3, done=1, pass=1, err_flags=0.
- Corrupt counter field of beat 5 (0-based), count=2, length=4 → err_flags=4'b0001, error_count=1, first_err_beat=5, pass=0.
- TLAST asserted on beat 2 of a length-4 packet, followed by a correct 4-beat packet, count=2 → err_flags[3]=1, error_count=1, packets_received=2, done=1.
- Random TVALID gaps (~50%), count=5, length=7 → 35 beats, pass=1; TREADY never deasserts mid-run.
- start pulsed after beat 3 of a run with an injected error at beat 1 → statistics cleared, new run passes clean, no stale flags.
- error_count saturation with ERR_CNT_W=4 and 20 bad beats → error_count=15; reset mid-run → all outputs return to reset values next cycle.
